// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ==========================================================================
// Module : instruction_fetch_pkg  -- shared types and constants for the IF stage
// Rev    : 1.0
// ==========================================================================
package instruction_fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] dataBus_t;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetchState_e;

    localparam dataBus_t C_NOP_INSTR = 32'h0000_0013;
    localparam dataBus_t C_RESET_PC  = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_skid_buffer.sv
`default_nettype none
// ==========================================================================
// Module : instruction_fetch_skid_buffer  -- 1-entry {inst, pc} holding slot
// Rev    : 1.0
// ==========================================================================
module instruction_fetch_skid_buffer
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_inst,
    input  logic [DATA_WIDTH-1:0] i_pc,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic [DATA_WIDTH-1:0] o_pc
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (i_clear) begin
            valid_d = 1'b0;
        end else if (i_load) begin
            valid_d = 1'b1;
            inst_d  = i_inst;
            pc_d    = i_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign o_valid = valid_q;
    assign o_inst  = inst_q;
    assign o_pc    = pc_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ==========================================================================
// Module : instruction_fetch  -- IF stage: PC, req/gnt/rvalid fetch, IF/ID reg
// Rev    : 1.0
// ==========================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = C_RESET_PC,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = C_NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  i_stall,
    input  logic                  i_redirect,
    input  logic [DATA_WIDTH-1:0] i_redirect_pc,
    output logic                  o_imem_req,
    output logic [DATA_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_gnt,
    input  logic                  i_imem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    output logic [DATA_WIDTH-1:0] o_if_inst,
    output logic [DATA_WIDTH-1:0] o_if_pc,
    output logic                  o_if_bubble
);

    localparam logic [DATA_WIDTH-1:0] C_INC = DATA_WIDTH'(4);

    fetchState_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [DATA_WIDTH-1:0] if_inst_q, if_inst_d;
    logic [DATA_WIDTH-1:0] if_pc_q, if_pc_d;
    logic                  if_bubble_q, if_bubble_d;

    logic                  w_advance;
    logic                  w_back_to_back;
    logic [DATA_WIDTH-1:0] w_redirect_pc;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic                  w_skid_load;
    logic                  w_skid_clear;
    logic                  w_skid_valid;
    logic [DATA_WIDTH-1:0] w_skid_inst;
    logic [DATA_WIDTH-1:0] w_skid_pc;

    assign w_advance      = clk_en & ~i_stall;
    assign w_redirect_pc  = i_redirect_pc & ~DATA_WIDTH'(3);
    assign w_next_pc      = req_pc_q + C_INC;
    assign w_back_to_back = (state_q == WAIT) & i_imem_rvalid & w_advance & ~i_redirect;

    instruction_fetch_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_inst  (i_imem_rdata),
        .i_pc    (req_pc_q),
        .o_valid (w_skid_valid),
        .o_inst  (w_skid_inst),
        .o_pc    (w_skid_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            if_inst_q   <= NOP_INSTR;
            if_pc_q     <= '0;
            if_bubble_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            if_inst_q   <= if_inst_d;
            if_pc_q     <= if_pc_d;
            if_bubble_q <= if_bubble_d;
        end
    end

    // A response consumed in DROP always returns to REQ, even alongside a new redirect
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            REQ:  if (!i_redirect && i_imem_gnt) state_d = WAIT;
            WAIT: begin
                if (i_redirect)          state_d = i_imem_rvalid ? REQ : DROP;
                else if (i_imem_rvalid)  state_d = !w_advance ? HOLD : (i_imem_gnt ? WAIT : REQ);
            end
            HOLD: if (i_redirect || w_advance) state_d = REQ;
            DROP: if (i_imem_rvalid) state_d = REQ;
            default: state_d = REQ;
        endcase
    end

    always_comb begin
        o_imem_req   = 1'b0;
        o_imem_addr  = pc_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;

        unique case (state_q)
            REQ: begin
                // A redirect withdraws the ungranted request so no stale grant can occur
                o_imem_req = ~i_redirect;
                if (i_imem_gnt && !i_redirect) req_pc_d = pc_q;
            end
            WAIT: begin
                if (w_back_to_back) begin
                    o_imem_req  = 1'b1;
                    o_imem_addr = w_next_pc;
                    pc_d        = w_next_pc;
                    if (i_imem_gnt) req_pc_d = w_next_pc;
                end else if (i_imem_rvalid && !w_advance && !i_redirect) begin
                    w_skid_load = 1'b1;
                end
            end
            HOLD: begin
                if (w_advance) begin
                    pc_d         = w_skid_pc + C_INC;
                    w_skid_clear = 1'b1;
                end
            end
            default: ;
        endcase

        if (i_redirect) begin
            pc_d         = w_redirect_pc;
            w_skid_clear = 1'b1;
        end

        if_inst_d   = if_inst_q;
        if_pc_d     = if_pc_q;
        if_bubble_d = if_bubble_q;
        if (i_redirect || (w_advance && !w_back_to_back && !(state_q == HOLD && w_skid_valid))) begin
            if_inst_d   = NOP_INSTR;
            if_bubble_d = 1'b1;
        end else if (w_back_to_back) begin
            if_inst_d   = i_imem_rdata;
            if_pc_d     = req_pc_q;
            if_bubble_d = 1'b0;
        end else if (w_advance) begin
            if_inst_d   = w_skid_inst;
            if_pc_d     = w_skid_pc;
            if_bubble_d = 1'b0;
        end
    end

    assign o_if_inst   = if_inst_q;
    assign o_if_pc     = if_pc_q;
    assign o_if_bubble = if_bubble_q;

endmodule
`default_nettype wire
